// File: rtl/sm_issue_arbiter.sv
// rtl/sm_issue_arbiter.sv - dual-issue slot arbiter fed from a two-word instruction ROM port
//
// Purpose: fetches imData1/imData2 at word PC imAddr and fills slot0, plus slot1
// when the two words can legally issue together. The slot registers hold while the
// pipeline stalls, and a redirect inserts a one-cycle FLUSH bubble.
// Optional feature: define SM_ISSUE_STATS_EN to add the dualCount/singleCount
// load counters.
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   imAddr                      ROM word address (combinational from PC)
//   imData1, imData2            ROM words at imAddr and imAddr+1
//   redirValid, redirAddr       redirect to byte address redirAddr (bits [1:0] ignored)
//   issueReady                  pipeline accepts the current slots
//   slot{0,1}Valid/Instr/Pc     registered issue slots (Pc is a byte address)
//   dualCount, singleCount      (SM_ISSUE_STATS_EN only) RUN-state load counters
module sm_issue_arbiter #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imAddr,
  input  logic [31:0] imData1,
  input  logic [31:0] imData2,
  input  logic        redirValid,
  input  logic [31:0] redirAddr,
  input  logic        issueReady,
  output logic        slot0Valid,
  output logic [31:0] slot0Instr,
  output logic [31:0] slot0Pc,
  output logic        slot1Valid,
  output logic [31:0] slot1Instr,
  output logic [31:0] slot1Pc
`ifdef SM_ISSUE_STATS_EN
  ,
  output logic [31:0] dualCount,
  output logic [31:0] singleCount
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        slot0_valid_q, slot0_valid_d;
  logic [31:0] slot0_instr_q, slot0_instr_d;
  logic [31:0] slot0_pc_q, slot0_pc_d;
  logic        slot1_valid_q, slot1_valid_d;
  logic [31:0] slot1_instr_q, slot1_instr_d;
  logic [31:0] slot1_pc_q, slot1_pc_d;

  // PC is always kept below SIZE, so a single conditional subtract is enough.
  function automatic logic [31:0] wrap_add(input logic [31:0] pc, input logic [31:0] inc);
    logic [32:0] s;
    s = {1'b0, pc} + {1'b0, inc};
    if (s >= 33'(SIZE)) s = s - 33'(SIZE);
    return s[31:0];
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == 7'b0000011) || (op == 7'b0100011);
  endfunction

  logic [4:0]  rd1, rd2, rs1_2, rs2_2;
  logic [6:0]  op1, op2;
  logic        dual_ok, load_en;
  logic [31:0] pc_plus1, pc_plus2, redir_pc;
  logic        unused_redir_lsbs;

  assign rd1    = imData1[11:7];
  assign op1    = imData1[6:0];
  assign rd2    = imData2[11:7];
  assign rs1_2  = imData2[19:15];
  assign rs2_2  = imData2[24:20];
  assign op2    = imData2[6:0];

  // rd1 == 0 already fails the RAW term, so the WAW term only needs rd1 != rd2 or rd2 == 0.
  assign dual_ok = (rd1 != 5'd0) && (rd1 != rs1_2) && (rd1 != rs2_2)
                 && ((rd1 != rd2) || (rd2 == 5'd0))
                 && (op1 != 7'b1100011) && (op1 != 7'b1101111) && (op1 != 7'b1100111)
                 && !(is_mem(op1) && is_mem(op2))
                 && (pc_q != 32'(SIZE - 1));

  assign pc_plus1 = wrap_add(pc_q, 32'd1);
  assign pc_plus2 = wrap_add(pc_q, 32'd2);
  assign redir_pc = {2'b00, redirAddr[31:2]} % 32'(SIZE);
  assign unused_redir_lsbs = ^redirAddr[1:0];

  // Redirect wins over everything; FLUSH never loads.
  assign load_en = !redirValid && (state_q != ST_FLUSH) && (!slot0_valid_q || issueReady);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    slot0_valid_d = slot0_valid_q;
    slot0_instr_d = slot0_instr_q;
    slot0_pc_d    = slot0_pc_q;
    slot1_valid_d = slot1_valid_q;
    slot1_instr_d = slot1_instr_q;
    slot1_pc_d    = slot1_pc_q;
    if (redirValid) begin
      pc_d          = redir_pc;
      slot0_valid_d = 1'b0;
      slot1_valid_d = 1'b0;
      state_d       = ST_FLUSH;
    end else if (state_q == ST_FLUSH) begin
      slot0_valid_d = 1'b0;
      slot1_valid_d = 1'b0;
      state_d       = ST_RUN;
    end else if (load_en) begin
      slot0_valid_d = 1'b1;
      slot0_instr_d = imData1;
      slot0_pc_d    = {pc_q[29:0], 2'b00};
      slot1_valid_d = dual_ok;
      slot1_instr_d = imData2;
      slot1_pc_d    = {pc_plus1[29:0], 2'b00};
      pc_d          = dual_ok ? pc_plus2 : pc_plus1;
      state_d       = ST_RUN;
    end else begin
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= 32'd0;
      slot0_valid_q <= 1'b0;
      slot0_instr_q <= 32'd0;
      slot0_pc_q    <= 32'd0;
      slot1_valid_q <= 1'b0;
      slot1_instr_q <= 32'd0;
      slot1_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      slot0_valid_q <= slot0_valid_d;
      slot0_instr_q <= slot0_instr_d;
      slot0_pc_q    <= slot0_pc_d;
      slot1_valid_q <= slot1_valid_d;
      slot1_instr_q <= slot1_instr_d;
      slot1_pc_q    <= slot1_pc_d;
    end
  end

  assign imAddr     = pc_q;
  assign slot0Valid = slot0_valid_q;
  assign slot0Instr = slot0_instr_q;
  assign slot0Pc    = slot0_pc_q;
  assign slot1Valid = slot1_valid_q;
  assign slot1Instr = slot1_instr_q;
  assign slot1Pc    = slot1_pc_q;

`ifdef SM_ISSUE_STATS_EN
  logic [31:0] dual_cnt_q, single_cnt_q;
  logic        count_en;

  // Only plain RUN-state loads are counted; the edge leaving HOLD is not.
  assign count_en = load_en && (state_q == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dual_cnt_q   <= 32'd0;
      single_cnt_q <= 32'd0;
    end else if (count_en) begin
      if (dual_ok) dual_cnt_q <= dual_cnt_q + 32'd1;
      else single_cnt_q <= single_cnt_q + 32'd1;
    end
  end

  assign dualCount   = dual_cnt_q;
  assign singleCount = single_cnt_q;
`endif

endmodule
